// File: rtl/data_memory.sv
// data_memory: single-ported word memory with a fixed-latency load path.
// The block handles one request at a time. A load returns after LATENCY cycles
// through a valid/ready response channel. A store writes on the acceptance edge.
// Optional macro DMEM_STORE_ACK_EN: a store also returns a response, with the
// same states and latency as a load.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// BUSY  | load in flight, countdown running
// RESP  | response held on resp_* until resp_ready
module data_memory #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [31:0] req_tag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [31:0] resp_tag,
    output logic        resp_err
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        count_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       tag_q;
    logic              oor_q;

    logic [31:0]       mem [MEM_WORDS];

    logic [29:0]       req_idx;
    logic              req_oor;
    logic              req_fire;
    logic              take_resp;
    logic [31:0]       rd_direct;
    logic [31:0]       rd_latched;
    logic [31:0]       direct_data;
    logic [31:0]       latched_data;
    logic              unused_addr_bits;

    // Byte lane bits do not select anything; all accesses are whole words.
    assign unused_addr_bits = ^req_addr[1:0];

    assign req_idx   = req_addr[31:2];
    assign req_oor   = (req_idx >= 30'(MEM_WORDS));
    assign req_ready = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign req_fire  = req_valid && req_ready;

    assign rd_direct  = req_oor ? 32'h0 : mem[req_idx[IDX_W-1:0]];
    assign rd_latched = oor_q ? 32'h0 : mem[idx_q];

`ifdef DMEM_STORE_ACK_EN
    logic        wr_q;
    logic [31:0] wdata_q;

    // Store data and the write flag are kept so that a store ack can echo the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
        end else if (req_fire) begin
            wr_q    <= req_write;
            wdata_q <= req_data;
        end
    end

    assign take_resp    = req_fire;
    assign direct_data  = req_write ? req_data : rd_direct;
    assign latched_data = wr_q ? wdata_q : rd_latched;
`else
    assign take_resp    = req_fire && !req_write;
    assign direct_data  = rd_direct;
    assign latched_data = rd_latched;
`endif

    // The memory array has no reset, so its contents survive a reset.
    // An out-of-range store is dropped.
    always_ff @(posedge clk) begin
        if (req_fire && req_write && !req_oor) begin
            mem[req_idx[IDX_W-1:0]] <= req_data;
        end
    end

    // Request/response sequencing. resp_* is loaded once, on entry to RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            idx_q     <= '0;
            tag_q     <= 32'h0;
            oor_q     <= 1'b0;
            resp_data <= 32'h0;
            resp_tag  <= 32'h0;
            resp_err  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_resp) begin
                        tag_q <= req_tag;
                        idx_q <= req_idx[IDX_W-1:0];
                        oor_q <= req_oor;
                        if (LATENCY == 1) begin
                            state_q   <= RESP;
                            resp_data <= direct_data;
                            resp_tag  <= req_tag;
                            resp_err  <= req_oor;
                        end else begin
                            state_q <= BUSY;
                            count_q <= 4'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    count_q <= count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_q   <= RESP;
                        resp_data <= latched_data;
                        resp_tag  <= tag_q;
                        resp_err  <= oor_q;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (MEM_WORDS=32, LATENCY=3).
module tb_data_memory;

    localparam int MEM_WORDS = 32;
    localparam int LATENCY   = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [31:0] resp_tag;
    logic        resp_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_mem [MEM_WORDS];

    data_memory #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check1(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] tag, input string name);
        @(negedge clk);
        check1({name, ":req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        req_tag   = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Called right after the acceptance edge. A nonzero stall holds resp_ready low
    // for that many edges. During the stall a store to 0x0 is offered, which the
    // DUT must ignore.
    task automatic wait_resp(input logic [31:0] tag, input logic [31:0] exp_data,
                             input logic exp_err, input logic chk_data, input int stall,
                             input string name);
        int cyc;
        resp_ready = (stall == 0);
        cyc = 0;
        @(negedge clk);
        while (!resp_valid && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        check32({name, ":latency"}, 32'(cyc + 1), 32'(LATENCY));
        check32({name, ":resp_tag"}, resp_tag, tag);
        check1({name, ":resp_err"}, resp_err, exp_err);
        if (chk_data) check32({name, ":resp_data"}, resp_data, exp_data);
        if (stall > 0) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'h0;
            req_data  = 32'hBAD0_BAD0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check1({name, ":stall_valid"}, resp_valid, 1'b1);
                check1({name, ":stall_ready"}, req_ready, 1'b0);
                check32({name, ":stall_data"}, resp_data, exp_data);
                check32({name, ":stall_tag"}, resp_tag, tag);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check1({name, ":valid_drop"}, resp_valid, 1'b0);
        check1({name, ":ready_back"}, req_ready, 1'b1);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] tag,
                           input logic [31:0] exp_data, input logic exp_err,
                           input logic chk_data, input int stall, input string name);
        drive_req(1'b0, addr, 32'h0, tag, name);
        wait_resp(tag, exp_data, exp_err, chk_data, stall, name);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] tag, input logic exp_err, input string name);
        drive_req(1'b1, addr, data, tag, name);
`ifdef DMEM_STORE_ACK_EN
        wait_resp(tag, data, exp_err, 1'b1, 0, name);
`else
        if (exp_err) begin
            @(negedge clk);
            check1({name, ":no_resp"}, resp_valid, 1'b0);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_data   = 32'h0;
        req_tag    = 32'h0;
        resp_ready = 1'b1;

        #2;
        check1("rst:req_ready", req_ready, 1'b1);
        check1("rst:resp_valid", resp_valid, 1'b0);
        check32("rst:resp_data", resp_data, 32'h0);
        check32("rst:resp_tag", resp_tag, 32'h0);
        check1("rst:resp_err", resp_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First load: memory is still uninitialized, so only timing, tag and err are checked.
        do_load(32'h10, 32'd5, 32'h0, 1'b0, 1'b0, 0, "load_0x10");

        for (int i = 0; i < MEM_WORDS; i++) begin
            exp_mem[i] = 32'hC0DE_0000 | 32'(i);
            do_store(32'(4 * i), exp_mem[i], 32'(100 + i), 1'b0, "fill");
        end

        do_store(32'h20, 32'hDEAD_BEEF, 32'd6, 1'b0, "store_0x20");
        exp_mem[8] = 32'hDEAD_BEEF;
        do_load(32'h23, 32'd7, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, "load_0x23");

        do_load(32'h44, 32'd3, exp_mem[17], 1'b0, 1'b1, 4, "stall_0x44");
        do_load(32'h0, 32'd1, exp_mem[0], 1'b0, 1'b1, 0, "ignored_store");

        do_load(32'(4 * MEM_WORDS), 32'd12, 32'h0, 1'b1, 1'b1, 0, "oor_load");
        do_store(32'(4 * MEM_WORDS), 32'hFFFF_FFFF, 32'd13, 1'b1, "oor_store");
        for (int i = 0; i < MEM_WORDS; i++) begin
            do_load(32'(4 * i), 32'(200 + i), exp_mem[i], 1'b0, 1'b1, 0, "readback");
        end

        do_store(32'h40, 32'h0000_1234, 32'd14, 1'b0, "store_0x40");
        exp_mem[16] = 32'h0000_1234;
        drive_req(1'b0, 32'h40, 32'h0, 32'd15, "rst_load");
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check1("midrst:req_ready", req_ready, 1'b1);
        check1("midrst:resp_valid", resp_valid, 1'b0);
        check32("midrst:resp_data", resp_data, 32'h0);
        check32("midrst:resp_tag", resp_tag, 32'h0);
        check1("midrst:resp_err", resp_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1("midrst:no_resp", resp_valid, 1'b0);
        end
        do_load(32'h40, 32'd16, 32'h0000_1234, 1'b0, 1'b1, 0, "after_rst");

        do_store(32'h8, 32'h55, 32'd9, 1'b0, "store_0x8");
        exp_mem[2] = 32'h55;
`ifndef DMEM_STORE_ACK_EN
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check1("store_noack:resp_valid", resp_valid, 1'b0);
            check1("store_noack:req_ready", req_ready, 1'b1);
        end
`endif
        do_load(32'h8, 32'd10, exp_mem[2], 1'b0, 1'b1, 0, "load_0x8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 3: cycles from load acceptance to resp_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address (Address type).
REQ-009 SHALL have port req_data  input  32  store data (MemoryWord type).
REQ-010 SHALL have port req_tag  input  32  LSQ tag (int) of the requesting entry.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-013 SHALL have port resp_data  output  32  load data (MemoryWord type).
REQ-014 SHALL have port resp_tag  output  32  tag echoed from the request.
REQ-015 SHALL have port resp_err  output  1  address was out of range.

Function
REQ-016 Request accepted on a rising edge where req_valid && req_ready; response delivered on a rising edge where resp_valid && resp_ready.
REQ-017 Word index = req_addr[31:2]; req_addr[1:0] ignored; index >= MEM_WORDS is out of range.
REQ-018 FSM states: IDLE, BUSY, RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-019 IDLE, load accepted: latch tag and index; go to RESP if LATENCY==1, else to BUSY with countdown loaded to LATENCY-1.
REQ-020 BUSY: countdown decrements each cycle; move to RESP on the edge where it reaches 0, so resp_valid rises exactly LATENCY cycles after acceptance.
REQ-021 On entry to RESP, resp_data = mem[index] (0 if out of range), resp_tag = latched tag, resp_err = out-of-range flag.
REQ-022 RESP: resp_data, resp_tag and resp_err stable until the handshake; on handshake go to IDLE, and resp_valid drops the next cycle.
REQ-023 Store accepted in IDLE: mem[index] <= req_data on the acceptance edge; out-of-range stores leave memory unchanged.
REQ-024 Requests are serviced one at a time, in acceptance order; a load issued after a store to the same index returns the stored value.
REQ-025 req_valid while req_ready=0 is ignored; the requester holds the request until accepted.

Reset
REQ-026 While reset=1: state IDLE, countdown 0, req_ready 1, resp_valid 0, resp_data 0, resp_tag 0, resp_err 0; takes effect without a clock edge.
REQ-027 Reset during BUSY or RESP SHALL discard the pending load with no response; reset SHALL NOT clear memory contents.

Configuration
REQ-028 Macro DMEM_STORE_ACK_EN: when defined, an accepted store behaves like a load (same states and latency); it returns resp_tag = req_tag, resp_data = req_data and resp_err per REQ-021, and the write still occurs on the acceptance edge.
REQ-029 Without DMEM_STORE_ACK_EN, a store produces no response and the block stays in IDLE with req_ready=1.

Verification
REQ-030 Reset, then load addr 0x10, tag 5, LATENCY=3, resp_ready=1 -> resp_valid high exactly 3 cycles after acceptance, resp_tag=5, resp_err=0.
REQ-031 Store 0xDEADBEEF to 0x20, then load 0x23, tag 7 -> resp_data=0xDEADBEEF, resp_tag=7.
REQ-032 Load with resp_ready held 0 for 4 cycles -> resp_valid, resp_data and resp_tag stable and req_ready=0 throughout; handshake on cycle 5, then req_ready=1 the following cycle.
REQ-033 Load addr 4*MEM_WORDS -> resp_data=0, resp_err=1; store to that address -> no memory word changes.
REQ-034 Assert reset 1 cycle into BUSY -> outputs reach reset values immediately and no response follows; a prior store to 0x40 of 0x1234 still reads back 0x1234.
REQ-035 With DMEM_STORE_ACK_EN, store 0x55 to 0x8, tag 9 -> response after LATENCY cycles with resp_tag=9, resp_data=0x55; without the macro, no resp_valid and req_ready stays 1.
